// File: rtl/xif_core_offload.sv
// XIF offload front-end: hands one instruction at a time to a coprocessor,
// tracks outstanding IDs and routes results to the register file.
module xif_core_offload #(
  parameter int X_ID_WIDTH = 4,
  parameter int X_NUM_RS   = 2,
  parameter int XLEN       = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       instr_valid,
  output logic                       instr_ready,
  input  logic [31:0]                instr_data,
  input  logic [X_NUM_RS*XLEN-1:0]   instr_rs,
  input  logic                       flush,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [31:0]                issue_instr,
  output logic [1:0]                 issue_mode,
  output logic [X_ID_WIDTH-1:0]      issue_id,
  output logic [X_NUM_RS*XLEN-1:0]   issue_rs,
  output logic [X_NUM_RS-1:0]        issue_rs_valid,
  output logic [5:0]                 issue_ecs,
  output logic                       issue_ecs_valid,
  input  logic                       issue_accept,
  input  logic                       issue_writeback,
  output logic                       commit_valid,
  output logic [X_ID_WIDTH-1:0]      commit_id,
  output logic                       commit_kill,
  input  logic                       result_valid,
  output logic                       result_ready,
  input  logic [X_ID_WIDTH-1:0]      result_id,
  input  logic [XLEN-1:0]            result_data,
  input  logic [4:0]                 result_rd,
  input  logic                       result_we,
  input  logic                       result_exc,
  input  logic [5:0]                 result_exccode,
  output logic                       rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [XLEN-1:0]            rf_wdata,
  output logic                       exc_valid,
  output logic [5:0]                 exc_code,
  output logic [X_ID_WIDTH-1:0]      exc_id,
  output logic                       illegal_instr,
  output logic                       spurious_result,
  output logic                       busy
);

  localparam int NID = 1 << X_ID_WIDTH;
  localparam int RSW = X_NUM_RS * XLEN;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    COMMIT
  } state_t;

  state_t state;
  state_t state_nx;

  logic                  live;
  logic [31:0]           instr_q;
  logic [RSW-1:0]        rs_q;
  logic [X_ID_WIDTH-1:0] id_q;
  logic [X_ID_WIDTH-1:0] next_id;
  logic [NID-1:0]        outstanding;
  logic [NID-1:0]        out_set;
  logic [NID-1:0]        out_clr;

  logic take;
  logic acc;
  logic rej;
  logic in_commit;
  logic res_spur;
  logic res_hit;
  logic res_wr;
  logic res_exc;
  logic unused_wb;

  assign issue_mode      = 2'b11;
  assign issue_ecs       = 6'b0;
  assign issue_ecs_valid = 1'b1;
  assign result_ready    = 1'b1;
  assign unused_wb       = issue_writeback;

  assign take      = instr_valid && instr_ready;
  assign acc       = (state == ISSUE) && issue_ready && issue_accept;
  assign rej       = (state == ISSUE) && issue_ready && !issue_accept;
  assign in_commit = (state == COMMIT);

  // a result racing its own commit is treated as not yet legitimate
  assign res_spur = result_valid &&
                    (!outstanding[result_id] ||
                     (in_commit && (result_id == id_q)));
  assign res_hit  = result_valid && !res_spur;
  assign res_wr   = res_hit && result_we && !result_exc && (|result_rd);
  assign res_exc  = res_hit && result_exc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (take) state_nx = ISSUE;
      end
      ISSUE: begin
        if (issue_ready) begin
          state_nx = issue_accept ? COMMIT : IDLE;
        end
      end
      COMMIT: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    instr_ready    = 1'b0;
    issue_valid    = 1'b0;
    issue_instr    = '0;
    issue_id       = '0;
    issue_rs       = '0;
    issue_rs_valid = '0;
    commit_valid   = 1'b0;
    commit_id      = '0;
    commit_kill    = 1'b0;
    busy           = (state != IDLE) || (|outstanding);
    unique case (state)
      IDLE: begin
        instr_ready = live && !outstanding[next_id];
      end
      ISSUE: begin
        issue_valid    = 1'b1;
        issue_instr    = instr_q;
        issue_id       = id_q;
        issue_rs       = rs_q;
        issue_rs_valid = '1;
      end
      COMMIT: begin
        commit_valid = 1'b1;
        commit_id    = id_q;
        commit_kill  = flush;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      rs_q    <= '0;
      id_q    <= '0;
    end else if (take) begin
      instr_q <= instr_data;
      rs_q    <= instr_rs;
      id_q    <= next_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_id <= '0;
      live    <= 1'b0;
    end else begin
      live <= 1'b1;
      if (in_commit) next_id <= next_id + X_ID_WIDTH'(1);
    end
  end

  // set and clear target different IDs by construction
  always_comb begin
    out_set = '0;
    out_clr = '0;
    if (acc) out_set[id_q] = 1'b1;
    if (in_commit && flush) out_clr[id_q] = 1'b1;
    if (res_hit) out_clr[result_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      outstanding <= (outstanding | out_set) & ~out_clr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= res_wr;
      if (res_wr) begin
        rf_waddr <= result_rd;
        rf_wdata <= result_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_valid <= 1'b0;
      exc_code  <= '0;
      exc_id    <= '0;
    end else begin
      exc_valid <= res_exc;
      if (res_exc) begin
        exc_code <= result_exccode;
        exc_id   <= result_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_instr   <= 1'b0;
      spurious_result <= 1'b0;
    end else begin
      illegal_instr   <= rej;
      spurious_result <= res_spur;
    end
  end

endmodule

// File: doc/xif_core_offload.md
XIF_CORE_OFFLOAD -- requirements
Module: xif_core_offload

Interface
REQ-001 SHALL have parameter X_ID_WIDTH, default 4, meaning instruction ID width; ID space is 2^X_ID_WIDTH entries.
REQ-002 SHALL have parameter X_NUM_RS, default 2, meaning number of source operands per offload.
REQ-003 SHALL have parameter XLEN, default 32, meaning integer register and operand width.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; ports as follows:
  clk  in  1  clock, all state on rising edge
  rst_n  in  1  asynchronous active-low reset
  instr_valid  in  1  core has an instruction to offload
  instr_ready  out  1  block can take an instruction
  instr_data  in  32  instruction word
  instr_rs  in  X_NUM_RS*XLEN  source operands
  flush  in  1  kill request for the instruction being committed
  issue_valid  out  1  XIF issue request valid
  issue_ready  in  1  coprocessor takes issue request
  issue_instr  out  32  offloaded instruction
  issue_mode  out  2  privilege level, constant 2'b11
  issue_id  out  X_ID_WIDTH  instruction ID
  issue_rs  out  X_NUM_RS*XLEN  operands
  issue_rs_valid  out  X_NUM_RS  operand validity, all ones while issue_valid
  issue_ecs  out  6  constant 6'b0
  issue_ecs_valid  out  1  constant 1
  issue_accept  in  1  coprocessor accepts instruction
  issue_writeback  in  1  coprocessor will write rd
  commit_valid  out  1  commit strobe
  commit_id  out  X_ID_WIDTH  committed ID
  commit_kill  out  1  kill the committed ID
  result_valid  in  1  result present
  result_ready  out  1  result taken, constant 1
  result_id  in  X_ID_WIDTH  result ID
  result_data  in  XLEN  writeback data
  result_rd  in  5  destination register
  result_we  in  1  write enable
  result_exc  in  1  synchronous exception
  result_exccode  in  6  exception code
  rf_we  out  1  integer register file write enable
  rf_waddr  out  5  write address
  rf_wdata  out  XLEN  write data
  exc_valid  out  1  one-cycle exception pulse
  exc_code  out  6  exception code
  exc_id  out  X_ID_WIDTH  exception ID
  illegal_instr  out  1  one-cycle pulse, offload rejected
  spurious_result  out  1  one-cycle pulse, result for a non-outstanding ID
  busy  out  1  state != IDLE or any ID outstanding

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE, COMMIT.
REQ-006 instr_ready SHALL be 1 only in IDLE with outstanding[next_id]==0.
REQ-007 On instr_valid&&instr_ready the block SHALL latch instr_data/instr_rs/next_id and go to ISSUE.
REQ-008 In ISSUE, issue_valid SHALL be 1 and all issue_* fields SHALL stay stable until issue_ready.
REQ-009 On ISSUE with issue_ready&&issue_accept: outstanding[issue_id] SHALL be set and the FSM SHALL go to COMMIT.
REQ-010 On ISSUE with issue_ready&&!issue_accept: illegal_instr SHALL pulse, next_id SHALL be unchanged, and the FSM SHALL go to IDLE.
REQ-011 In COMMIT, the block SHALL drive commit_valid=1 for exactly one cycle, with commit_id = latched ID and commit_kill = flush sampled that cycle; then go to IDLE.
REQ-012 On a commit with kill, outstanding[id] SHALL clear on the same edge; next_id SHALL increment (mod 2^X_ID_WIDTH, wrap) on every commit.
REQ-013 A result with result_valid and outstanding[result_id]==1 SHALL clear outstanding[result_id].
REQ-014 A result with outstanding[result_id]==0, or with result_id equal to the ID in COMMIT that cycle, SHALL pulse spurious_result and cause no write, exception or state change.
REQ-015 For a valid non-spurious result with result_we=1, result_exc=0 and result_rd!=0, the block SHALL assert rf_we/rf_waddr/rf_wdata on the next cycle (latency 1); for rd==0 there SHALL be no write.
REQ-016 For a valid non-spurious result with result_exc=1, the block SHALL suppress the write and pulse exc_valid with exc_code and exc_id on the next cycle.
REQ-017 An issue-accept set and a result clear of different IDs on the same edge SHALL both take effect.

Reset
REQ-018 While rst_n=0, the block SHALL be in IDLE, next_id=0, outstanding all 0, and all outputs 0 except the constants (issue_mode=2'b11, issue_ecs_valid=1, result_ready=1).
REQ-019 Reset asserted mid-ISSUE or mid-COMMIT SHALL abort immediately, with no commit emitted after release.

Verification
REQ-020 Offload 0x00C5_8553, accept=1, writeback=1 -> commit id0 kill0; result id0 rd=10 data=0xDEAD_BEEF -> rf_we on the next cycle, rf_waddr=10, busy then 0.
REQ-021 issue_accept=0 -> illegal_instr pulse once, next offload reuses id0.
REQ-022 flush=1 during COMMIT -> commit_kill=1, outstanding cleared; a later result id0 -> spurious_result, no rf_we.
REQ-023 Issue 16 instructions with results withheld -> after 16 issues instr_ready=0 (outstanding[0] set, IDs wrapped); return result id0 -> instr_ready=1 and the next issue uses id0.
REQ-024 Result with exc=1, exccode=6'd2 -> exc_valid pulse with exc_code=2 and no rf_we; result with rd=0, we=1 -> no rf_we.
REQ-025 Deassert rst_n during ISSUE -> issue_valid=0 immediately; no commit_valid after release; next_id=0.
